// File: rtl/pwr_mgmt_scanner.sv
// Power-management mux scanner: steps an external mux through NUM_CH channels, debounces the
// shared data line per channel into status bits, with sticky change flags, irq and kill switch.
module pwr_mgmt_scanner #(
    parameter int unsigned NUM_CH     = 8,
    parameter int unsigned MUX_W      = 3,
    parameter int unsigned SETTLE_CYC = 50,
    parameter int unsigned DEBOUNCE   = 4,
    parameter int unsigned KILL_CH    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    output logic [MUX_W-1:0] mux,
    input  logic             data,
    output logic             kill_sw,
    output logic             scan_done
);

    localparam int unsigned SetW = $clog2(SETTLE_CYC);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StNext} state_e;

    state_e              state_q, state_d;
    logic [MUX_W-1:0]    ch_q, ch_d;
    logic [SetW-1:0]     settle_q, settle_d;
    logic                data_meta_q, data_sync_q;
    logic [NUM_CH-1:0]   status_q, status_d;
    logic [NUM_CH-1:0]   change_q, change_d, change_set, change_w1c;
    logic [3:0]          cnt_q [NUM_CH];
    logic [3:0]          cnt_d [NUM_CH];
    logic [3:0]          cnt_inc;
    logic [1:0]          ctrl_q, ctrl_d;
    logic [31:0]         readdata_q, readdata_d;
    logic                irq_q, kill_q, scan_done_q, scan_done_d;
    logic                last_ch, settle_last;
    logic                unused_wdata;

    assign last_ch      = (ch_q == MUX_W'(NUM_CH - 1));
    assign settle_last  = (settle_q == SetW'(SETTLE_CYC - 1));
    assign unused_wdata = ^writedata[31:NUM_CH];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StSettle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; scan_en is only honoured at slot boundaries
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (ctrl_q[0]) state_d = StSettle;
            StSettle: if (settle_last) state_d = StSample;
            StSample: state_d = StNext;
            StNext:   state_d = ctrl_q[0] ? StSettle : StIdle;
            default:  state_d = StSettle;
        endcase
    end

    // Datapath / output next-state logic
    always_comb begin
        ch_d        = ch_q;
        settle_d    = settle_q;
        status_d    = status_q;
        cnt_d       = cnt_q;
        change_set  = '0;
        scan_done_d = 1'b0;
        cnt_inc     = cnt_q[ch_q] + 4'd1;
        unique case (state_q)
            StIdle: begin
                if (ctrl_q[0]) begin
                    ch_d     = '0;
                    settle_d = '0;
                end
            end
            StSettle: settle_d = settle_last ? '0 : settle_q + 1'b1;
            StSample: begin
                if (data_sync_q == status_q[ch_q]) begin
                    cnt_d[ch_q] = '0;
                end else if (cnt_inc == 4'(DEBOUNCE)) begin
                    status_d[ch_q]   = ~status_q[ch_q];
                    change_set[ch_q] = 1'b1;
                    cnt_d[ch_q]      = '0;
                end else begin
                    cnt_d[ch_q] = cnt_inc;
                end
            end
            StNext: begin
                scan_done_d = last_ch;
                ch_d        = last_ch ? '0 : ch_q + 1'b1;
                settle_d    = '0;
            end
            default: ;
        endcase
    end

    // Bus side; reads see pre-write values, and a same-cycle set beats W1C
    always_comb begin
        change_w1c = (write && address == 2'd1) ? writedata[NUM_CH-1:0] : '0;
        change_d   = (change_q & ~change_w1c) | change_set;
        ctrl_d     = (write && address == 2'd2) ? writedata[1:0] : ctrl_q;
        readdata_d = readdata_q;
        if (read) begin
            readdata_d = '0;
            unique case (address)
                2'd0: readdata_d[NUM_CH-1:0] = status_q;
                2'd1: readdata_d[NUM_CH-1:0] = change_q;
                2'd2: readdata_d[1:0]        = ctrl_q;
                2'd3: begin
                    readdata_d[15:8] = 8'(ch_q);
                    readdata_d[7:0]  = 8'(NUM_CH);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_q        <= '0;
            settle_q    <= '0;
            data_meta_q <= 1'b0;
            data_sync_q <= 1'b0;
            status_q    <= '0;
            change_q    <= '0;
            cnt_q       <= '{default: '0};
            ctrl_q      <= 2'b01;
            readdata_q  <= '0;
            irq_q       <= 1'b0;
            kill_q      <= 1'b0;
            scan_done_q <= 1'b0;
        end else begin
            ch_q        <= ch_d;
            settle_q    <= settle_d;
            data_meta_q <= data;
            data_sync_q <= data_meta_q;
            status_q    <= status_d;
            change_q    <= change_d;
            cnt_q       <= cnt_d;
            ctrl_q      <= ctrl_d;
            readdata_q  <= readdata_d;
            irq_q       <= ctrl_q[1] & (|change_q);
            kill_q      <= status_q[KILL_CH];
            scan_done_q <= scan_done_d;
        end
    end

    assign mux       = ch_q;
    assign readdata  = readdata_q;
    assign irq       = irq_q;
    assign kill_sw   = kill_q;
    assign scan_done = scan_done_q;

endmodule
